qdec_bitstream_feeder: RTL and testbench

Byte-stream source that drives the CABAC bitstream fetch port (`dout`/`dout_vld`/`dout_rdy` → `bitstreamFetch*`). It reads a byte range from a 32-bit word-addressed bitstream RAM, unpacks it little-endian and presents one byte per handshake. It sits between the bitstream RAM and `qdec_cabac` and replaces the bench-side FIFO in system builds. A start/abort/busy/done control set is driven from the register block.

---
 rtl/qdec_bitstream_feeder_if.sv | 22 ++
 rtl/qdec_bitstream_feeder.sv | 191 +++++++++++++++++++
 tb/tb_qdec_bitstream_feeder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qdec_bitstream_feeder_if.sv
// Bitstream feeder bus: word-RAM read port plus the byte stream towards qdec_cabac.
// master = feeder side, slave = RAM/consumer side.
interface qdec_bitstream_feeder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [31:0]           mem_rdata;
  logic [7:0]            dout;
  logic                  dout_vld;
  logic                  dout_rdy;

  modport master (
    output mem_re, mem_raddr, dout, dout_vld,
    input  mem_rdata, dout_rdy
  );

  modport slave (
    input  mem_re, mem_raddr, dout, dout_vld,
    output mem_rdata, dout_rdy
  );
endinterface

// File: rtl/qdec_bitstream_feeder.sv
// Streams a byte range out of a 32-bit word RAM, little-endian, one byte per handshake.
// Start-to-first-byte latency is 3 cycles; a 2-word credit-controlled buffer absorbs dout_rdy stalls.
module qdec_bitstream_feeder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH+1:0]  start_byte_addr,
  input  logic [LEN_WIDTH-1:0]   byte_len,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  qdec_bitstream_feeder_if.master bus
);

  localparam int WLW = LEN_WIDTH + 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [WLW-1:0]        words_left_q, words_left_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]  unpack_left_q, unpack_left_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [31:0]           fifo_q [2];
  logic [31:0]           fifo_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            dout_q, dout_d;
  logic                  dout_vld_q, dout_vld_d;
  logic                  done_q, done_d;

  logic                  run;
  logic                  accept;
  logic                  mem_re_c;
  logic                  head_vld;
  logic [31:0]           head_word;
  logic [7:0]            head_byte;
  logic                  load;
  logic                  pop;
  logic                  pop_fifo;
  logic                  push;
  logic [WLW-1:0]        wl_sum;

  assign run    = (state_q == S_RUN);
  assign accept = dout_vld_q && bus.dout_rdy;

  // The returning read word is usable in the same cycle it lands, so the first byte is not delayed by the FIFO.
  assign head_vld  = (cnt_q != 2'd0) || rd_pend_q;
  assign head_word = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q] : bus.mem_rdata;
  assign head_byte = head_word[{byte_idx_q, 3'b000} +: 8];

  assign mem_re_c = run && (words_left_q != '0)
                    && (({1'b0, cnt_q} + {2'b00, rd_pend_q}) < 3'd2);

  assign wl_sum = {1'b0, byte_len} + {{(WLW-2){1'b0}}, start_byte_addr[1:0]} + WLW'(3);

  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    words_left_d  = words_left_q;
    remaining_d   = remaining_q;
    unpack_left_d = unpack_left_q;
    byte_idx_d    = byte_idx_q;
    rd_pend_d     = 1'b0;
    fifo_d        = fifo_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    dout_d        = dout_q;
    dout_vld_d    = dout_vld_q;
    done_d        = 1'b0;
    load          = 1'b0;
    pop           = 1'b0;
    pop_fifo      = 1'b0;
    push          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (byte_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d       = S_RUN;
            waddr_d       = start_byte_addr[ADDR_WIDTH+1:2];
            byte_idx_d    = start_byte_addr[1:0];
            remaining_d   = byte_len;
            unpack_left_d = byte_len;
            words_left_d  = wl_sum >> 2;
          end
        end
      end

      S_RUN: begin
        if (mem_re_c) begin
          waddr_d      = waddr_q + ADDR_WIDTH'(1);
          words_left_d = words_left_q - WLW'(1);
        end
        rd_pend_d = mem_re_c;

        if (abort || (accept && remaining_q == LEN_WIDTH'(1))) begin
          // Both exits drop any buffered or in-flight words; only a normal finish reports done.
          state_d      = S_IDLE;
          done_d       = !abort;
          rd_pend_d    = 1'b0;
          cnt_d        = 2'd0;
          rd_ptr_d     = 1'b0;
          wr_ptr_d     = 1'b0;
          dout_vld_d   = 1'b0;
          words_left_d = '0;
          remaining_d  = '0;
        end else begin
          if (accept) begin
            remaining_d = remaining_q - LEN_WIDTH'(1);
            dout_vld_d  = 1'b0;
          end
          load = (!dout_vld_q || accept) && head_vld && (unpack_left_q != '0);
          if (load) begin
            dout_d        = head_byte;
            dout_vld_d    = 1'b1;
            byte_idx_d    = byte_idx_q + 2'd1;
            unpack_left_d = unpack_left_q - LEN_WIDTH'(1);
            pop           = (byte_idx_q == 2'd3) || (unpack_left_q == LEN_WIDTH'(1));
          end
          // A bypassed word that is finished in its arrival cycle never needs a FIFO slot.
          push     = rd_pend_q && !((cnt_q == 2'd0) && pop);
          pop_fifo = pop && (cnt_q != 2'd0);
          if (push) begin
            fifo_d[wr_ptr_q] = bus.mem_rdata;
            wr_ptr_d         = ~wr_ptr_q;
          end
          if (pop_fifo) begin
            rd_ptr_d = ~rd_ptr_q;
          end
          cnt_d = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q       <= S_IDLE;
      waddr_q       <= '0;
      words_left_q  <= '0;
      remaining_q   <= '0;
      unpack_left_q <= '0;
      byte_idx_q    <= 2'd0;
      rd_pend_q     <= 1'b0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      dout_q        <= 8'd0;
      dout_vld_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      words_left_q  <= words_left_d;
      remaining_q   <= remaining_d;
      unpack_left_q <= unpack_left_d;
      byte_idx_q    <= byte_idx_d;
      rd_pend_q     <= rd_pend_d;
      fifo_q[0]     <= fifo_d[0];
      fifo_q[1]     <= fifo_d[1];
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      cnt_q         <= cnt_d;
      dout_q        <= dout_d;
      dout_vld_q    <= dout_vld_d;
      done_q        <= done_d;
    end
  end

  assign busy          = run;
  assign done          = done_q;
  assign bus.mem_re    = mem_re_c;
  assign bus.mem_raddr = waddr_q;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_qdec_bitstream_feeder.sv
// Randomized bench for qdec_bitstream_feeder: two instances (16-bit and 4-bit word address)
// checked against a byte-level reference built from the RAM image and the start/len request.
module tb_qdec_bitstream_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [17:0] start_byte_addr = '0;
  logic [19:0] byte_len = '0;
  logic        abort = 1'b0;
  logic        dout_rdy = 1'b0;
  bit          sel = 1'b0;

  logic        busy_a, done_a, busy_w, done_w;
  logic        start_a, start_w;

  qdec_bitstream_feeder_if #(.ADDR_WIDTH(16)) bus_a ();
  qdec_bitstream_feeder_if #(.ADDR_WIDTH(4))  bus_w ();

  logic [31:0] ram_a [256];
  logic [31:0] ram_w [16];

  int n_tests = 0;
  int n_fail  = 0;
  int first_vld_cyc, done_cyc, n_re, done_cnt, last_acc_cyc;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_w = start & sel;
  assign bus_a.dout_rdy = dout_rdy;
  assign bus_w.dout_rdy = dout_rdy;

  qdec_bitstream_feeder #(.ADDR_WIDTH(16), .LEN_WIDTH(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_byte_addr(start_byte_addr),
    .byte_len(byte_len), .abort(abort), .busy(busy_a), .done(done_a), .bus(bus_a)
  );

  qdec_bitstream_feeder #(.ADDR_WIDTH(4), .LEN_WIDTH(20)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .start_byte_addr(start_byte_addr[5:0]),
    .byte_len(byte_len), .abort(abort), .busy(busy_w), .done(done_w), .bus(bus_w)
  );

  // RAM models: one-cycle read latency, garbage on the bus when not reading.
  always @(posedge clk) begin
    bus_a.mem_rdata <= bus_a.mem_re ? ram_a[bus_a.mem_raddr[7:0]] : $urandom();
    bus_w.mem_rdata <= bus_w.mem_re ? ram_w[bus_w.mem_raddr] : $urandom();
  end

  logic        s_busy, s_done, s_mem_re, s_vld;
  logic [15:0] s_raddr;
  logic [7:0]  s_dout;
  assign s_busy   = sel ? busy_w : busy_a;
  assign s_done   = sel ? done_w : done_a;
  assign s_mem_re = sel ? bus_w.mem_re : bus_a.mem_re;
  assign s_raddr  = sel ? {12'd0, bus_w.mem_raddr} : bus_a.mem_raddr;
  assign s_vld    = sel ? bus_w.dout_vld : bus_a.dout_vld;
  assign s_dout   = sel ? bus_w.dout : bus_a.dout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ram_byte(input bit s, input int a);
    logic [31:0] w;
    w = s ? ram_w[(a >> 2) % 16] : ram_a[(a >> 2) % 256];
    return w[8*(a % 4) +: 8];
  endfunction

  // One transfer; abort_after >= 0 aborts once that many bytes are accepted,
  // restart_cyc > 0 fires a second start while busy.
  task automatic run_xfer(input bit s, input int addr, input int len, input int rdy_pct,
                          input int abort_after, input int restart_cyc);
    logic [7:0] exp_q[$];
    int  aw_words, base_w, n_words, acc, cyc, popped, b;
    bit  prev_stall, aborted;
    logic [7:0] prev_dout;
    aw_words = s ? 16 : 65536;
    base_w   = addr >> 2;
    n_words  = (len == 0) ? 0 : ((addr % 4) + len + 3) / 4;
    acc = 0; cyc = 0; prev_stall = 0; aborted = 0; prev_dout = 8'd0;
    for (int i = 0; i < len; i++) exp_q.push_back(ram_byte(s, addr + i));
    first_vld_cyc = -1; done_cyc = -1; n_re = 0; done_cnt = 0; last_acc_cyc = -1;

    sel = s;
    @(negedge clk);
    start = 1'b1; start_byte_addr = 18'(addr); byte_len = 20'(len); dout_rdy = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (cyc < 3000) begin
      dout_rdy = ($urandom_range(99) < rdy_pct);
      if (restart_cyc == cyc) begin
        start = 1'b1; start_byte_addr = 18'(addr + 36); byte_len = 20'd3;
      end
      if (!aborted && abort_after >= 0 && acc == abort_after) begin
        abort = 1'b1; dout_rdy = 1'b0; aborted = 1'b1;
      end
      if (s_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (s_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (prev_stall) chk("hold", {s_vld, s_dout}, {1'b1, prev_dout});
      b = acc + int'(s_vld);
      popped = (b >= len) ? n_words : ((addr % 4) + b) / 4;
      if (s_busy) chk("credit", 32'((n_re + int'(s_mem_re) - popped) <= 2), 32'd1);
      if (s_mem_re) begin
        chk("raddr", s_raddr, 32'((base_w + n_re) % aw_words));
        n_re++;
      end
      if (s_vld && dout_rdy) begin
        if (exp_q.size() == 0) chk("byte_count", acc + 1, len);
        else chk("byte", s_dout, exp_q.pop_front());
        acc++;
        last_acc_cyc = cyc;
      end
      prev_stall = s_vld && !dout_rdy;
      prev_dout  = s_dout;
      if (!s_busy) break;
      @(negedge clk);
      start = 1'b0; abort = 1'b0; cyc++;
      if (aborted) begin
        chk("abort_busy", s_busy, 0);
        chk("abort_vld", s_vld, 0);
        chk("abort_done", s_done, 0);
        break;
      end
    end
    chk("end_idle", s_busy, 0);
    @(negedge clk);
    dout_rdy = 1'b0;
    chk("done_width", s_done, 0);
    if (!aborted) begin
      chk("done_cnt", done_cnt, 1);
      chk("bytes", acc, len);
      chk("reads", n_re, n_words);
      chk("done_time", done_cyc, (len > 0) ? last_acc_cyc + 1 : 1);
    end else begin
      chk("abort_no_done", done_cnt, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_a[i] = $urandom();
    for (int i = 0; i < 16; i++)  ram_w[i] = $urandom();

    repeat (2) @(negedge clk);
    chk("rst_busy", {busy_a, busy_w}, 0);
    chk("rst_done", {done_a, done_w}, 0);
    chk("rst_mem_re", {bus_a.mem_re, bus_w.mem_re}, 0);
    chk("rst_raddr", {bus_a.mem_raddr, bus_w.mem_raddr}, 0);
    chk("rst_dout", {bus_a.dout, bus_w.dout}, 0);
    chk("rst_vld", {bus_a.dout_vld, bus_w.dout_vld}, 0);
    rst_n = 1'b0;

    // Aligned, full rate: bytes in cycles 3..10, done in 11.
    ram_a[0] = 32'h44332211; ram_a[1] = 32'h88776655;
    run_xfer(0, 0, 8, 100, -1, 0);
    chk("aligned_first", first_vld_cyc, 3);
    chk("aligned_done", done_cyc, 11);

    // Unaligned: 44,55,66,77,88.
    run_xfer(0, 3, 5, 100, -1, 0);
    chk("unaligned_first", first_vld_cyc, 3);

    // Backpressure with a 0x00..0x0F byte ramp.
    for (int i = 0; i < 4; i++) ram_a[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    run_xfer(0, 0, 16, 30, -1, 0);

    // Zero length, then a start while busy.
    run_xfer(0, 20, 0, 100, -1, 0);
    chk("zero_vld", first_vld_cyc, -1);
    run_xfer(0, 8, 10, 100, -1, 4);

    // Abort after 3 of 12, then a fresh 4-byte transfer elsewhere.
    for (int i = 0; i < 16; i++) ram_a[i] = $urandom();
    run_xfer(0, 0, 12, 100, 3, 0);
    run_xfer(0, 16, 4, 100, -1, 0);

    // Word address wrap on the narrow instance: words 15 then 0.
    run_xfer(1, 60, 8, 100, -1, 0);
    chk("wrap_first", first_vld_cyc, 3);

    // Reset mid-transfer drops it without done.
    sel = 1'b0;
    @(negedge clk);
    start = 1'b1; start_byte_addr = 18'd4; byte_len = 20'd20; dout_rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", s_busy, 0);
    chk("midrst_vld", s_vld, 0);
    chk("midrst_mem_re", s_mem_re, 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", s_done, 0);
    end
    dout_rdy = 1'b0;

    // Randomized transfers on both instances.
    for (int t = 0; t < 12; t++) begin
      bit s;
      s = t[0];
      for (int i = 0; i < 256; i++) ram_a[i] = $urandom();
      for (int i = 0; i < 16; i++)  ram_w[i] = $urandom();
      if (s) run_xfer(1, $urandom_range(0, 63), $urandom_range(1, 40), $urandom_range(20, 100), -1, 0);
      else   run_xfer(0, $urandom_range(0, 400), $urandom_range(1, 48), $urandom_range(20, 100),
                      (t % 4 == 2) ? $urandom_range(0, 3) : -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
